// File: rtl/alu_pkg.sv
// Shared widths, opcode encodings and result payload for the 8-bit ALU.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL  = 4'b0010;
    localparam logic [OP_W-1:0] OP_DIV  = 4'b0011;
    localparam logic [OP_W-1:0] OP_INC  = 4'b0100;
    localparam logic [OP_W-1:0] OP_DEC  = 4'b0101;
    localparam logic [OP_W-1:0] OP_NEG  = 4'b0110;
    localparam logic [OP_W-1:0] OP_PASS = 4'b0111;
    localparam logic [OP_W-1:0] OP_AND  = 4'b1000;
    localparam logic [OP_W-1:0] OP_OR   = 4'b1001;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b1010;
    localparam logic [OP_W-1:0] OP_NAND = 4'b1011;
    localparam logic [OP_W-1:0] OP_NOR  = 4'b1100;
    localparam logic [OP_W-1:0] OP_XNOR = 4'b1101;
    localparam logic [OP_W-1:0] OP_SHL  = 4'b1110;
    localparam logic [OP_W-1:0] OP_SHR  = 4'b1111;

    // Everything the execute stage produces in one cycle.
    typedef struct packed {
        logic [DATA_W-1:0] f;
        logic [DATA_W-1:0] ff;
        logic              equal;
        logic              gt;
        logic              lt;
        logic              zero;
        logic              carry;
        logic              ovf;
    } alu_res_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: next result, extended result and flags from A, B, S.
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [OP_W-1:0]   s_i,
    output alu_res_t          res_c
);

    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;

    // Opcode decode and arithmetic; zero and compare flags are derived afterwards.
    always_comb begin
        res_c = '0;
        sum   = '0;
        prod  = '0;
        case (s_i)
            OP_ADD: begin
                sum         = {1'b0, a_i} + {1'b0, b_i};
                res_c.f     = sum[DATA_W-1:0];
                res_c.carry = sum[DATA_W];
                res_c.ovf   = (a_i[7] == b_i[7]) && (sum[7] != a_i[7]);
            end
            OP_SUB: begin
                sum         = {1'b0, a_i} - {1'b0, b_i};
                res_c.f     = sum[DATA_W-1:0];
                res_c.carry = sum[DATA_W];
                res_c.ovf   = (a_i[7] != b_i[7]) && (sum[7] != a_i[7]);
            end
            OP_MUL: begin
                prod      = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
                res_c.f   = prod[DATA_W-1:0];
                res_c.ff  = prod[2*DATA_W-1:DATA_W];
                res_c.ovf = |prod[2*DATA_W-1:DATA_W];
            end
            OP_DIV: begin
                // Divide-by-zero returns all-ones quotient and passes A through as remainder.
                if (b_i == 8'h00) begin
                    res_c.f   = 8'hFF;
                    res_c.ff  = a_i;
                    res_c.ovf = 1'b1;
                end else begin
                    res_c.f  = a_i / b_i;
                    res_c.ff = a_i % b_i;
                end
            end
            OP_INC: begin
                sum         = {1'b0, a_i} + 9'd1;
                res_c.f     = sum[DATA_W-1:0];
                res_c.carry = sum[DATA_W];
                res_c.ovf   = (a_i == 8'h7F);
            end
            OP_DEC: begin
                sum         = {1'b0, a_i} - 9'd1;
                res_c.f     = sum[DATA_W-1:0];
                res_c.carry = sum[DATA_W];
                res_c.ovf   = (a_i == 8'h80);
            end
            OP_NEG: begin
                res_c.f   = ~a_i + 8'd1;
                res_c.ovf = (a_i == 8'h80);
            end
            OP_PASS: res_c.f = a_i;
            OP_AND:  res_c.f = a_i & b_i;
            OP_OR:   res_c.f = a_i | b_i;
            OP_XOR:  res_c.f = a_i ^ b_i;
            OP_NAND: res_c.f = ~(a_i & b_i);
            OP_NOR:  res_c.f = ~(a_i | b_i);
            OP_XNOR: res_c.f = ~(a_i ^ b_i);
            OP_SHL: begin
                res_c.f     = {a_i[6:0], 1'b0};
                res_c.carry = a_i[7];
            end
            OP_SHR: begin
                res_c.f     = {1'b0, a_i[7:1]};
                res_c.carry = a_i[0];
            end
            default: ;
        endcase

        // MUL counts the full 16-bit product as the result for the zero flag.
        if (s_i == OP_MUL) begin
            res_c.zero = ({res_c.ff, res_c.f} == 16'h0000);
        end else begin
            res_c.zero = (res_c.f == 8'h00);
        end

        res_c.equal = (a_i == b_i);
        res_c.gt    = (a_i > b_i);
        res_c.lt    = (a_i < b_i);
    end

endmodule

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU execute stage: one op per cycle, one cycle latency.
module alu_8bit
    import alu_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   S,
    output logic [DATA_W-1:0] F,
    output logic [DATA_W-1:0] FF,
    output logic              EQUAL,
    output logic              GT,
    output logic              LT,
    output logic              Zero,
    output logic              CarryOut,
    output logic              Overflow
);

    alu_res_t core_res_c;
    alu_res_t res_d;
    alu_res_t res_q;

    alu_core u_core (
        .a_i   (A),
        .b_i   (B),
        .s_i   (S),
        .res_c (core_res_c)
    );

    // Next-state of the output register is the core result.
    always_comb begin
        res_d = core_res_c;
    end

    // Output register with synchronous reset that clears every field.
    always_ff @(posedge CLK) begin
        if (RST) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign F        = res_q.f;
    assign FF       = res_q.ff;
    assign EQUAL    = res_q.equal;
    assign GT       = res_q.gt;
    assign LT       = res_q.lt;
    assign Zero     = res_q.zero;
    assign CarryOut = res_q.carry;
    assign Overflow = res_q.ovf;

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: driver queues hand-computed results, monitor checks each edge.
module tb_alu_8bit;

    typedef struct packed {
        logic [7:0] f;
        logic [7:0] ff;
        logic       eq;
        logic       gt;
        logic       lt;
        logic       z;
        logic       c;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [3:0] s = 4'h0;
    logic [7:0] f, ff;
    logic       eq, gt, lt, z, c, o;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;
    logic  done = 1'b0;

    always #5 clk = ~clk;

    alu_8bit dut (
        .CLK      (clk),
        .RST      (rst),
        .A        (a),
        .B        (b),
        .S        (s),
        .F        (f),
        .FF       (ff),
        .EQUAL    (eq),
        .GT       (gt),
        .LT       (lt),
        .Zero     (z),
        .CarryOut (c),
        .Overflow (o)
    );

    // Drive one op at the falling edge and queue its expected registered response.
    task automatic apply(input string nm, input logic r, input logic [7:0] av, input logic [7:0] bv,
                         input logic [3:0] sv, input logic [7:0] ef, input logic [7:0] eff,
                         input logic eeq, input logic egt, input logic elt,
                         input logic ez, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        rst = r;
        a   = av;
        b   = bv;
        s   = sv;
        e   = '{f: ef, ff: eff, eq: eeq, gt: egt, lt: elt, z: ez, c: ec, o: eo};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: every result is presented 1 ns after the capturing edge.
    initial begin
        exp_t  act;
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = '{f: f, ff: ff, eq: eq, gt: gt, lt: lt, z: z, c: c, o: o};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got F=%h FF=%h eq/gt/lt=%b%b%b Z=%b C=%b V=%b, want F=%h FF=%h eq/gt/lt=%b%b%b Z=%b C=%b V=%b",
                             nm, act.f, act.ff, act.eq, act.gt, act.lt, act.z, act.c, act.o,
                             e.f, e.ff, e.eq, e.gt, e.lt, e.z, e.c, e.o);
                end
            end
        end
    end

    initial begin
        //     name          rst   A      B      S      F      FF     eq gt lt z  c  o
        apply("reset",       1'b1, 8'h5A, 8'h33, 4'h0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        apply("add_0_0",     1'b0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 1, 0, 0, 1, 0, 0);
        apply("sub_0f_05",   1'b0, 8'h0F, 8'h05, 4'h1, 8'h0A, 8'h00, 0, 1, 0, 0, 0, 0);
        apply("add_7f_01",   1'b0, 8'h7F, 8'h01, 4'h0, 8'h80, 8'h00, 0, 1, 0, 0, 0, 1);
        apply("add_ff_01",   1'b0, 8'hFF, 8'h01, 4'h0, 8'h00, 8'h00, 0, 1, 0, 1, 1, 0);
        apply("sub_05_0f",   1'b0, 8'h05, 8'h0F, 4'h1, 8'hF6, 8'h00, 0, 0, 1, 0, 1, 0);
        apply("sub_80_01",   1'b0, 8'h80, 8'h01, 4'h1, 8'h7F, 8'h00, 0, 1, 0, 0, 0, 1);
        apply("mul_10_20",   1'b0, 8'h10, 8'h20, 4'h2, 8'h00, 8'h02, 0, 0, 1, 0, 0, 1);
        apply("mul_ff_ff",   1'b0, 8'hFF, 8'hFF, 4'h2, 8'h01, 8'hFE, 1, 0, 0, 0, 0, 1);
        apply("mul_00_33",   1'b0, 8'h00, 8'h33, 4'h2, 8'h00, 8'h00, 0, 0, 1, 1, 0, 0);
        apply("div_0c_0f",   1'b0, 8'h0C, 8'h0F, 4'h3, 8'h00, 8'h0C, 0, 0, 1, 1, 0, 0);
        apply("div_by_zero", 1'b0, 8'h37, 8'h00, 4'h3, 8'hFF, 8'h37, 0, 1, 0, 0, 0, 1);
        apply("div_64_07",   1'b0, 8'h64, 8'h07, 4'h3, 8'h0E, 8'h02, 0, 1, 0, 0, 0, 0);
        apply("inc_ff",      1'b0, 8'hFF, 8'hFF, 4'h4, 8'h00, 8'h00, 1, 0, 0, 1, 1, 0);
        apply("inc_7f",      1'b0, 8'h7F, 8'h00, 4'h4, 8'h80, 8'h00, 0, 1, 0, 0, 0, 1);
        apply("dec_00",      1'b0, 8'h00, 8'h00, 4'h5, 8'hFF, 8'h00, 1, 0, 0, 0, 1, 0);
        apply("dec_80",      1'b0, 8'h80, 8'h00, 4'h5, 8'h7F, 8'h00, 0, 1, 0, 0, 0, 1);
        apply("neg_80",      1'b0, 8'h80, 8'h80, 4'h6, 8'h80, 8'h00, 1, 0, 0, 0, 0, 1);
        apply("neg_01",      1'b0, 8'h01, 8'h01, 4'h6, 8'hFF, 8'h00, 1, 0, 0, 0, 0, 0);
        apply("pass_5a",     1'b0, 8'h5A, 8'h5A, 4'h7, 8'h5A, 8'h00, 1, 0, 0, 0, 0, 0);
        apply("and",         1'b0, 8'h0C, 8'h03, 4'h8, 8'h00, 8'h00, 0, 1, 0, 1, 0, 0);
        apply("or",          1'b0, 8'h0C, 8'h0A, 4'h9, 8'h0E, 8'h00, 0, 1, 0, 0, 0, 0);
        apply("xor",         1'b0, 8'h30, 8'h40, 4'hA, 8'h70, 8'h00, 0, 0, 1, 0, 0, 0);
        apply("nand",        1'b0, 8'h0F, 8'h45, 4'hB, 8'hFA, 8'h00, 0, 0, 1, 0, 0, 0);
        apply("nor",         1'b0, 8'h4C, 8'h0F, 4'hC, 8'hB0, 8'h00, 0, 1, 0, 0, 0, 0);
        apply("xnor",        1'b0, 8'h8C, 8'h03, 4'hD, 8'h70, 8'h00, 0, 1, 0, 0, 0, 0);
        apply("shl_ac",      1'b0, 8'hAC, 8'h00, 4'hE, 8'h58, 8'h00, 0, 1, 0, 0, 1, 0);
        apply("shr_ad",      1'b0, 8'hAD, 8'h00, 4'hF, 8'h56, 8'h00, 0, 1, 0, 0, 1, 0);

        // Inputs wiggled between edges must leave the registered SHR result untouched.
        @(posedge clk);
        #3;
        a = 8'h00;
        b = 8'h00;
        s = 4'h0;
        #1;
        checks++;
        if (f !== 8'h56 || c !== 1'b1 || z !== 1'b0 || eq !== 1'b0) begin
            errors++;
            $display("FAIL midcycle_hold: got F=%h C=%b Z=%b EQ=%b, want F=56 C=1 Z=0 EQ=0", f, c, z, eq);
        end

        apply("add_11_22",   1'b0, 8'h11, 8'h22, 4'h0, 8'h33, 8'h00, 0, 0, 1, 0, 0, 0);
        apply("reset_mid",   1'b1, 8'hFF, 8'hFF, 4'h2, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        apply("after_reset", 1'b0, 8'h20, 8'h10, 4'h1, 8'h10, 8'h00, 0, 1, 0, 0, 0, 0);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected results never checked, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
